// File: rtl/key_debouncer.sv
// key_debouncer
//
// Purpose:
//   Cleans up the board's active-low pushbuttons so that downstream pattern
//   logic (speed/direction control for the LED scanner) sees exactly one
//   event per physical press. Each key goes through a two-flop synchronizer
//   followed by its own four-state debounce machine with a single counter.
//
// Parameters:
//   NUM_KEYS        - number of independent pushbuttons
//   DEBOUNCE_CYCLES - consecutive stable synchronized samples needed to
//                     accept a change (2..65535)
//   REPEAT_DELAY    - cycles held before the first auto-repeat pulse
//   REPEAT_PERIOD   - cycles between later auto-repeat pulses
//
// Ports:
//   CLOCK_50    in   system clock, everything on its rising edge
//   reset       in   synchronous, active-high reset
//   KEY         in   raw asynchronous pushbuttons, 0 = pressed
//   key_down    out  debounced level, 1 = held
//   key_press   out  one-cycle pulse on accepted press (and auto-repeat)
//   key_release out  one-cycle pulse on accepted release
//
// Build option:
//   KEY_AUTOREPEAT_EN - when defined, a held key emits repeated key_press
//                       pulses after REPEAT_DELAY, then every REPEAT_PERIOD
//                       cycles. When undefined, no repeat logic exists and
//                       each accepted press yields exactly one pulse.

module key_debouncer #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    // Counter is sized from the largest interval it may ever have to hold,
    // with one spare bit so the terminal compare never needs a wrap.
    localparam int MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CYCLES = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
`else
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`endif

    // Debounce machine states
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_stable;
    logic [NUM_KEYS-1:0] pressed;

    // Two-flop synchronizer for every key. Flops come out of reset as
    // "released" (1) so a key held through reset is seen as a fresh press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_meta   <= '1;
            sync_stable <= '1;
        end else begin
            sync_meta   <= KEY;
            sync_stable <= sync_meta;
        end
    end

    // Flip polarity once here so the state machines work in "1 = pressed".
    assign pressed = ~sync_stable;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key

        logic [1:0]       state;
        logic [CNT_W-1:0] count;
        logic             down;
        logic             press_pulse;
        logic             release_pulse;
`ifdef KEY_AUTOREPEAT_EN
        logic             repeat_flag;
`endif

        // Per-key debounce machine. The wait states count consecutive
        // samples that disagree with the accepted level; any agreeing
        // sample sends the machine back and discards the partial count.
        // Pulses default low every cycle so each one lasts a single clock,
        // and press/release come from mutually exclusive branches.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                state         <= ST_IDLE;
                count         <= CNT_ZERO;
                down          <= 1'b0;
                press_pulse   <= 1'b0;
                release_pulse <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                repeat_flag   <= 1'b0;
`endif
            end else begin
                press_pulse   <= 1'b0;
                release_pulse <= 1'b0;

                case (state)
                    ST_IDLE: begin
                        if (pressed[i]) begin
                            count <= CNT_ONE;
                            state <= ST_PRESS_WAIT;
                        end
                    end

                    ST_PRESS_WAIT: begin
                        if (!pressed[i]) begin
                            count <= CNT_ZERO;
                            state <= ST_IDLE;
                        end else if (count == DEB_LAST) begin
                            count       <= CNT_ZERO;
                            state       <= ST_HELD;
                            down        <= 1'b1;
                            press_pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                            repeat_flag <= 1'b0;
`endif
                        end else begin
                            count <= count + 1'b1;
                        end
                    end

                    ST_HELD: begin
                        if (!pressed[i]) begin
                            count <= CNT_ONE;
                            state <= ST_RELEASE_WAIT;
                        end else begin
`ifdef KEY_AUTOREPEAT_EN
                            // First repeat waits the long delay, every
                            // later one the shorter period.
                            if (count == (repeat_flag ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
                                count       <= CNT_ZERO;
                                repeat_flag <= 1'b1;
                                press_pulse <= 1'b1;
                            end else begin
                                count <= count + 1'b1;
                            end
`else
                            // Nothing consumes this count without repeat;
                            // it simply saturates instead of wrapping.
                            if (count != CNT_MAX) begin
                                count <= count + 1'b1;
                            end
`endif
                        end
                    end

                    ST_RELEASE_WAIT: begin
                        if (pressed[i]) begin
                            // Bounce during release: back to held with the
                            // count cleared (repeat flag deliberately kept).
                            count <= CNT_ZERO;
                            state <= ST_HELD;
                        end else if (count == DEB_LAST) begin
                            count         <= CNT_ZERO;
                            state         <= ST_IDLE;
                            down          <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end

                    default: begin
                        count <= CNT_ZERO;
                        state <= ST_IDLE;
                        down  <= 1'b0;
                    end
                endcase
            end
        end

        assign key_down[i]    = down;
        assign key_press[i]   = press_pulse;
        assign key_release[i] = release_pulse;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Testbench for key_debouncer.
// Reference model: each key's accepted level flips once the most recent
// DEBOUNCE_CYCLES synchronized samples all disagree with it; synchronized
// samples are the raw KEY values delayed by two clocks and inverted.

module tb_key_debouncer;

   localparam int NK  = 2;
   localparam int D   = 16;
   localparam int RD  = 64;
   localparam int RP  = 16;
   localparam int LAT = D + 2;

   logic          CLOCK_50 = 1'b0;
   logic          reset    = 1'b1;
   logic [NK-1:0] KEY      = '1;
   logic [NK-1:0] key_down;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;

   int checks = 0;
   int fails  = 0;

   // Model state
   logic [NK-1:0] m_d1 = '1;
   logic [NK-1:0] m_d2 = '1;
   logic [D-1:0]  m_hist [NK];
   logic [NK-1:0] m_level     = '0;
   logic [NK-1:0] exp_down    = '0;
   logic [NK-1:0] exp_press   = '0;
   logic [NK-1:0] exp_release = '0;
`ifdef KEY_AUTOREPEAT_EN
   int            m_rc    [NK];
   bit            m_rflag [NK];
`endif

   key_debouncer #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .KEY         (KEY),
      .key_down    (key_down),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Counts a comparison and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Advance the reference model by one rising edge using the inputs that
   // were present at that edge.
   task automatic modelEdge();
      logic [NK-1:0] s_vec;
      logic          s;
      logic          prev;
      if (reset) begin
         m_d1        = '1;
         m_d2        = '1;
         m_level     = '0;
         exp_down    = '0;
         exp_press   = '0;
         exp_release = '0;
         for (int i = 0; i < NK; i++) begin
            m_hist[i] = '0;
`ifdef KEY_AUTOREPEAT_EN
            m_rc[i]    = 0;
            m_rflag[i] = 1'b0;
`endif
         end
      end else begin
         s_vec       = ~m_d2;
         m_d2        = m_d1;
         m_d1        = KEY;
         exp_press   = '0;
         exp_release = '0;
         for (int i = 0; i < NK; i++) begin
            s         = s_vec[i];
            prev      = m_hist[i][0];
            m_hist[i] = {m_hist[i][D-2:0], s};
            if (!m_level[i] && m_hist[i] == {D{1'b1}}) begin
               m_level[i]   = 1'b1;
               exp_press[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
               m_rc[i]    = 0;
               m_rflag[i] = 1'b0;
`endif
            end else if (m_level[i] && m_hist[i] == '0) begin
               m_level[i]     = 1'b0;
               exp_release[i] = 1'b1;
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (m_level[i] && s) begin
               if (!prev) begin
                  m_rc[i] = 0;
               end else if (m_rc[i] == (m_rflag[i] ? RP - 1 : RD - 1)) begin
                  exp_press[i] = 1'b1;
                  m_rc[i]      = 0;
                  m_rflag[i]   = 1'b1;
               end else begin
                  m_rc[i]++;
               end
            end
`else
            else begin
               prev = 1'b0;
            end
`endif
         end
         exp_down = m_level;
      end
   endtask

   // One clock: update the model at the edge, compare just after it.
   task automatic step();
      @(posedge CLOCK_50);
      modelEdge();
      #1;
      checkOutput("down", key_down, exp_down);
      checkOutput("press", key_press, exp_press);
      checkOutput("release", key_release, exp_release);
      checkOutput("press_and_release", key_press & key_release, 0);
   endtask

   task automatic applyStimulus(input logic [NK-1:0] k, input logic r, input int cycles);
      KEY   = k;
      reset = r;
      repeat (cycles) step();
   endtask

   // Number of edges until the chosen pulse appears on key idx (-1 = none).
   task automatic measureEdge(input int idx, input bit rel, input int limit, output int lat);
      lat = -1;
      for (int n = 1; n <= limit; n++) begin
         step();
         if (rel ? key_release[idx] : key_press[idx]) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      int            lat;
      int            npress;
      int            first_rep;
      int            cyc;
      int            dur;
      logic [NK-1:0] kr;

      for (int i = 0; i < NK; i++) m_hist[i] = '0;

      // Reset, then idle
      applyStimulus(2'b11, 1'b1, 3);
      checkOutput("reset_down", key_down, 0);
      applyStimulus(2'b11, 1'b0, 100);
      checkOutput("idle_down", key_down, 0);
      checkOutput("idle_press", key_press, 0);

      // Single press on key 0
      KEY = 2'b10;
      measureEdge(0, 1'b0, 40, lat);
      checkOutput("press_lat", lat, LAT);
      checkOutput("press_down", key_down, 2'b01);
      checkOutput("press_other", key_press[1], 0);

      // Keep holding and count any further press pulses
      npress    = 0;
      first_rep = -1;
      for (int n = 1; n <= 200; n++) begin
         step();
         if (key_press[0]) begin
            npress++;
            if (first_rep < 0) first_rep = n;
         end
      end
`ifdef KEY_AUTOREPEAT_EN
      checkOutput("repeat_count", npress, 9);
      checkOutput("repeat_first", first_rep, RD);
`else
      checkOutput("repeat_count", npress, 0);
`endif

      // Release
      KEY = 2'b11;
      measureEdge(0, 1'b1, 40, lat);
      checkOutput("release_lat", lat, LAT);
      checkOutput("release_down", key_down, 0);
      applyStimulus(2'b11, 1'b0, 10);

      // Bounce: low 10, high 3, then low for good
      npress = 0;
      KEY = 2'b10;
      for (int n = 0; n < 10; n++) begin
         step();
         if (key_press[0]) npress++;
      end
      KEY = 2'b11;
      for (int n = 0; n < 3; n++) begin
         step();
         if (key_press[0]) npress++;
      end
      checkOutput("glitch_no_press", npress, 0);
      KEY = 2'b10;
      measureEdge(0, 1'b0, 40, lat);
      checkOutput("glitch_lat", lat, LAT);
      applyStimulus(2'b11, 1'b0, 30);

      // Both keys together
      KEY = 2'b00;
      measureEdge(0, 1'b0, 40, lat);
      checkOutput("both_lat", lat, LAT);
      checkOutput("both_press", key_press, 2'b11);
      applyStimulus(2'b00, 1'b0, 5);
      KEY = 2'b11;
      measureEdge(0, 1'b1, 40, lat);
      checkOutput("both_rel_lat", lat, LAT);
      checkOutput("both_release", key_release, 2'b11);
      applyStimulus(2'b11, 1'b0, 10);

      // Reset while held, key stays held afterwards
      applyStimulus(2'b10, 1'b0, 30);
      checkOutput("held_before_reset", key_down, 2'b01);
      applyStimulus(2'b10, 1'b1, 1);
      checkOutput("reset_mid_down", key_down, 0);
      checkOutput("reset_mid_no_release", key_release, 0);
      KEY   = 2'b10;
      reset = 1'b0;
      measureEdge(0, 1'b0, 40, lat);
      checkOutput("rearm_lat", lat, LAT);
      applyStimulus(2'b11, 1'b0, 30);

      // Randomized segments: short bursts (bounce) and long stable holds
      cyc = 0;
      while (cyc < 3000) begin
         kr = NK'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            applyStimulus(kr, 1'b1, 1);
            cyc += 1;
         end else begin
            if ($urandom_range(0, 1) == 1) dur = int'($urandom_range(1, 6));
            else dur = int'($urandom_range(12, 40));
            applyStimulus(kr, 1'b0, dur);
            cyc += dur;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

- Input-side counterpart to the LED pattern drivers.
- Samples the board's active-low pushbuttons (`KEY`) on `CLOCK_50` and passes each one through a two-flop synchronizer and a per-key debounce state machine.
- Presents clean active-high levels plus single-cycle press/release pulses, so pattern logic (speed/direction control for the LED scanner) sees exactly one event per physical press.

## Interface
- `NUM_KEYS`, default 2: number of independent pushbuttons.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a change; legal range 2..65535.
- `REPEAT_DELAY`, default 64: cycles a key is held before the first auto-repeat pulse. Used only with `KEY_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 16: cycles between subsequent auto-repeat pulses. Used only with `KEY_AUTOREPEAT_EN`.
- `CLOCK_50`, input, 1: single system clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `KEY`, input, `NUM_KEYS`: raw asynchronous pushbuttons; active-low (0 = pressed).
- `key_down`, output, `NUM_KEYS`: debounced level; 1 = held.
- `key_press`, output, `NUM_KEYS`: one-cycle pulse on accepted press (and on auto-repeat, if enabled).
- `key_release`, output, `NUM_KEYS`: one-cycle pulse on accepted release.

## Operation
- Synchronizer: two flops per key.
  - Reset value 1 (released).
  - The synchronized value `s` is inverted so that 1 = pressed.
- Per key, a 4-state FSM with one counter. Counter width is `$clog2` of the largest of `DEBOUNCE_CYCLES`, `REPEAT_DELAY` and `REPEAT_PERIOD`, plus 1.
  - IDLE: `key_down`=0. On `s`=1: counter←1, go to PRESS_WAIT.
  - PRESS_WAIT:
    - If `s`=0: go back to IDLE; counter←0 (bounce rejected, no pulse).
    - Else if counter==`DEBOUNCE_CYCLES`-1: go to HELD; assert `key_press` for this one transition cycle; `key_down`←1; counter←0.
    - Else: counter+1.
  - HELD: `key_down`=1. On `s`=0: counter←1, go to RELEASE_WAIT.
  - RELEASE_WAIT: `key_down` stays 1.
    - If `s`=1: go back to HELD (bounce rejected).
    - Else if counter==`DEBOUNCE_CYCLES`-1: go to IDLE; `key_down`←0; pulse `key_release`.
    - Else: counter+1.
- Keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- `key_press` and `key_release` are never both high for the same key in one cycle.
- All outputs are registered.

## Timing
- Reset, applied in any state:
  - Synchronizer flops→1.
  - FSMs→IDLE, counters→0.
  - `key_down`, `key_press`, `key_release`→0 on the next edge.
  - No release pulse is generated by reset, even if a key was held mid-operation.
- Press latency: with `KEY` low and stable from before edge N, `key_down` rises and `key_press` pulses after edge N+1+`DEBOUNCE_CYCLES`. That is 2 synchronizer edges minus overlap; the bench checks exactly `DEBOUNCE_CYCLES`+2 edges after the first sampling edge.
- Release latency is identical: `DEBOUNCE_CYCLES`+2 edges.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized samples produces no output change, and the counter restarts from the next stable sample.
- Pulse width is exactly 1 cycle.
- Counters saturate in HELD when auto-repeat is disabled; they never wrap.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - In HELD, the counter counts cycles since acceptance.
  - At counter==`REPEAT_DELAY`-1, `key_press` pulses and the counter reloads to 0 with a repeat flag set.
  - After that, a pulse fires every `REPEAT_PERIOD` cycles while the key stays held.
  - Entering RELEASE_WAIT pauses repeat. Returning to HELD after a bounce resumes with the counter cleared and the repeat flag kept.
- `KEY_AUTOREPEAT_EN` undefined:
  - Exactly one `key_press` per accepted press.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored, and no repeat logic is synthesized.

## Test plan
- Reset, then KEY=2'b11 held 100 cycles -> `key_down`=0, no pulses.
- KEY[0]←0 and held, `DEBOUNCE_CYCLES`=16 -> `key_press[0]` single pulse and `key_down[0]`↑ exactly 18 edges after first sampling edge; KEY[1] outputs unchanged.
- KEY[0] low 10 cycles, high 3, low 20 -> one `key_press[0]` only, timed 18 edges after the final falling edge of KEY[0].
- Both keys pressed in the same cycle, later released in the same cycle -> simultaneous `key_press`=2'b11 pulse, later `key_release`=2'b11 pulse, never press+release together per key.
- Key held, `reset` asserted for 1 cycle mid-HELD -> `key_down`=0 next edge, no `key_release`. The still-held key is re-accepted with `key_press` 18 edges after reset deasserts.
- With `KEY_AUTOREPEAT_EN`, key held 200 cycles after acceptance (delay 64, period 16) -> repeat pulses at +64, +80, +96, ... relative to the initial press pulse. Without the macro -> only the initial pulse.
